// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: FIFO-buffered SET/RESET/TOGGLE/HOLD command issuer for a JK stage with q_fb checking.
// Optional feature macro JK_SEQ_ERR_CNT_EN adds an 8-bit saturating mismatch counter port err_cnt.
module jk_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  output logic                     cmd_ready,
  output logic                     j,
  output logic                     k,
  input  logic                     q_fb,
  input  logic                     err_clr,
  output logic                     busy,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fill
`ifdef JK_SEQ_ERR_CNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          j_q, j_d, k_q, k_d, exp_q, exp_d, err_q, err_d;
  logic          push, pop, last, mismatch;
  logic [1:0]    head;

  assign cmd_ready = fill_q != FW'(DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign last      = cnt_q == CW'(SETTLE - 1);
  assign pop       = fill_q != '0 && (state_q == IDLE || (state_q == CHECK && last));
  assign mismatch  = state_q == CHECK && last && q_fb != exp_q;
  assign head      = mem_q[rd_ptr_q];
  assign j         = j_q;
  assign k         = k_q;
  assign fill      = fill_q;
  assign err       = err_q;
  assign busy      = state_q != IDLE || fill_q != '0;

  // FIFO storage: op codes are bit-for-bit the J/K pair, so no decode is needed later
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_op;
  end

  // Next-state: FIFO pointers, FSM, one-cycle J/K pulse, expected-q model with resync on mismatch
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fill_d   = fill_q + FW'(push) - FW'(pop);
    j_d      = pop & head[1];
    k_d      = pop & head[0];
    state_d  = pop ? DRIVE : state_q == DRIVE ? CHECK : (state_q == CHECK && !last) ? CHECK : IDLE;
    cnt_d    = (state_q == CHECK && !last) ? cnt_q + CW'(1) : '0;
    exp_d    = state_q == DRIVE ? ((j_q & k_q) ? ~exp_q : j_q ? 1'b1 : k_q ? 1'b0 : exp_q)
             : mismatch ? q_fb : exp_q;
    err_d    = mismatch | (err_q & ~err_clr);
  end

  // State registers; reset drops every queued and in-flight command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      exp_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
    end
  end

`ifdef JK_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  assign err_cnt = err_cnt_q;

  // Saturating mismatch count; a mismatch coinciding with err_clr restarts the count at 1
  always_comb begin
    err_cnt_d = mismatch ? (err_clr ? 8'd1 : err_cnt_q == 8'hff ? 8'hff : err_cnt_q + 8'd1)
              : err_clr ? 8'd0 : err_cnt_q;
  end

  // Mismatch counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
`endif
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: scoreboard bench for jk_cmd_sequencer with an ideal JK stage model and fault injection.
module tb_jk_cmd_sequencer;
  logic       clk = 0, reset_n = 0, cmd_valid = 0, err_clr = 0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ready, j, k, q_fb, busy, err;
  logic [2:0] fill;
`ifdef JK_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  jk_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .j(j), .k(k), .q_fb(q_fb), .err_clr(err_clr),
    .busy(busy), .err(err), .fill(fill)
`ifdef JK_SEQ_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Ideal JK stage; drop=1 models a stuck stage that ignores its drive
  logic jk_q, drop = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) jk_q <= 1'b0;
    else if (!drop) begin
      case ({j, k})
        2'b10: jk_q <= 1'b1;
        2'b01: jk_q <= 1'b0;
        2'b11: jk_q <= ~jk_q;
        default: ;
      endcase
    end
  end
  assign q_fb = jk_q;

  typedef struct {logic [1:0] jk; logic q;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each J/K pulse pops one expected entry; the stage q is checked the following cycle
  logic q_pend = 0, q_exp = 0, prev_drive = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) prev_drive = 0;
    else begin
      if (q_pend) begin
        chk("q_after_drive", 32'(jk_q), 32'(q_exp));
        q_pend = 0;
      end
      if (j | k) begin
        chk("drive_one_cycle", 32'(prev_drive), 0);
        if (sb.size() == 0) chk("unexpected_drive", 32'({j, k}), 0);
        else begin
          e = sb.pop_front();
          chk("jk", 32'({j, k}), 32'(e.jk));
          q_pend = 1;
          q_exp  = e.q;
        end
      end
      prev_drive = j | k;
    end
  end

  int max_fill = 0;
  logic saw_full = 0;
  always @(negedge clk) begin
    if (int'(fill) > max_fill) max_fill = int'(fill);
    if (cmd_valid && !cmd_ready) saw_full = 1;
  end

  // Offer one command, hold valid until accepted (bounded); called and returns on a negedge
  task automatic push(input logic [1:0] op, input logic q_after);
    int t = 0;
    logic r;
    cmd_valid = 1;
    cmd_op = op;
    while (1) begin
      r = cmd_ready;
      @(posedge clk);
      if (r || t >= 50) break;
      t++;
      @(negedge clk);
    end
    if (r && op != 2'b00) sb.push_back('{jk: op, q: q_after});
    if (!r) chk("push_timeout", 32'(r), 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle", 32'(busy), 0);
  endtask

  task automatic pulse_clr;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  logic [1:0] t3_ops [9] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11};
  logic       t3_q   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_j", 32'(j), 0);
    chk("rst_k", 32'(k), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    push(2'b10, 1); push(2'b11, 0); push(2'b11, 1); push(2'b01, 0);
    wait_idle;
    chk("seq_err", 32'(err), 0);

    max_fill = 0; saw_full = 0;
    for (int i = 0; i < 9; i++) push(t3_ops[i], t3_q[i]);
    wait_idle;
    chk("max_fill", 32'(max_fill), 4);
    chk("saw_full_block", 32'(saw_full), 1);
    chk("sb_drained", 32'(sb.size()), 0);

    push(2'b01, 0);
    wait_idle;
    drop = 1;
    push(2'b10, 0);
    wait_idle;
    drop = 0;
    chk("stuck_set_err", 32'(err), 1);
    pulse_clr;
    chk("clr_alone", 32'(err), 0);
    push(2'b11, 1);
    wait_idle;
    chk("resync_no_cascade", 32'(err), 0);

    drop = 1;
    push(2'b01, 1);
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    @(negedge clk);
    err_clr = 0;
    chk("clr_vs_mismatch", 32'(err), 1);
    wait_idle;
    drop = 0;
    pulse_clr;
    chk("clr_alone2", 32'(err), 0);
    push(2'b00, 1);
    wait_idle;
    chk("hold_err", 32'(err), 0);

    drop = 1;
    push(2'b01, 1);
    wait_idle;
    drop = 0;
    chk("pre_reset_err", 32'(err), 1);
    push(2'b10, 1); push(2'b01, 0); push(2'b01, 0);
    @(negedge clk);
    chk("pre_reset_k", 32'(k), 1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_j", 32'(j), 0);
    chk("mid_rst_k", 32'(k), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    sb.delete();
    q_pend = 0;
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_jk", 32'({j, k}), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    push(2'b11, 1);
    wait_idle;
    chk("post_rst_err", 32'(err), 0);

`ifdef JK_SEQ_ERR_CNT_EN
    drop = 1;
    for (int i = 0; i < 260; i++) push(2'b11, 1);
    wait_idle;
    drop = 0;
    chk("err_cnt_sat", 32'(err_cnt), 255);
    chk("err_cnt_err", 32'(err), 1);
    pulse_clr;
    chk("err_cnt_clr", 32'(err_cnt), 0);
    chk("err_cnt_err_clr", 32'(err), 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
